// File: rtl/seq_pkg.sv
// seq_pkg: shared states, instruction classes, opcode patterns and control encodings
package seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_LD, C_ST, C_CB, C_B, C_ILL} iclass_t;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] M_ADDI  = 11'b11111111110;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] M_CBZ   = 11'b11111111000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] M_B     = 11'b11111100000;
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_ORR   = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;
    localparam logic [1:0] SEU_I  = 2'b00;
    localparam logic [1:0] SEU_D  = 2'b01;
    localparam logic [1:0] SEU_B  = 2'b10;
    localparam logic [1:0] SEU_CB = 2'b11;
    function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat, input logic [10:0] mask);
        return (op & mask) == pat;
    endfunction
endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: opcode/flag inputs, datapath controls and counters of the sequencer
interface multicycle_sequencer_if #(parameter int CNT_W = 32);
    logic [10:0] opcode;
    logic zero, mem_ack;
    logic ir_wr, pc_wr, pc_src, reg2loc, alu_src, mem_req, mem_wr, mem_to_reg, reg_wr, halted;
    logic [1:0] seu;
    logic [2:0] alu_op;
    logic [CNT_W-1:0] cycle_cnt, retired_cnt;
    modport master (
        input  opcode, zero, mem_ack,
        output ir_wr, pc_wr, pc_src, reg2loc, seu, alu_src, alu_op, mem_req, mem_wr,
               mem_to_reg, reg_wr, halted, cycle_cnt, retired_cnt
    );
    modport slave (
        output opcode, zero, mem_ack,
        input  ir_wr, pc_wr, pc_src, reg2loc, seu, alu_src, alu_op, mem_req, mem_wr,
               mem_to_reg, reg_wr, halted, cycle_cnt, retired_cnt
    );
endinterface

// File: rtl/seq_decode.sv
// seq_decode: classifies a latched LEGv8 opcode and picks the R-class ALU code
module seq_decode
    import seq_pkg::*;
(
    input  logic [10:0] i_opcode,
    output iclass_t     o_class,
    output logic [2:0]  o_alu_op
);
    always_comb begin
        o_class  = (i_opcode == OP_ADD || i_opcode == OP_SUB ||
                    i_opcode == OP_AND || i_opcode == OP_ORR) ? C_R  :
                   op_match(i_opcode, OP_ADDI, M_ADDI)        ? C_I  :
                   (i_opcode == OP_LDUR)                      ? C_LD :
                   (i_opcode == OP_STUR)                      ? C_ST :
                   op_match(i_opcode, OP_CBZ, M_CBZ)          ? C_CB :
                   op_match(i_opcode, OP_B, M_B)              ? C_B  : C_ILL;
        o_alu_op = (i_opcode == OP_SUB) ? ALU_SUB :
                   (i_opcode == OP_AND) ? ALU_AND :
                   (i_opcode == OP_ORR) ? ALU_ORR : ALU_ADD;
    end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: LEGv8 fetch/decode/exec/mem/wb control FSM with memory wait states.
// Define SEQ_PERF_CNT_EN to build the cycle and retired-instruction counters.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst_n,
    multicycle_sequencer_if.master bus
);
    state_t      r_state;
    logic [10:0] r_opcode;
    iclass_t     w_class;
    logic [2:0]  w_r_alu;
    logic        w_ex, w_mem, w_wb, w_alu;

    seq_decode u_decode (
        .i_opcode (r_opcode),
        .o_class  (w_class),
        .o_alu_op (w_r_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH: begin
                    r_opcode <= bus.opcode;
                    r_state  <= S_DECODE;
                end
                S_DECODE: r_state <= (w_class == C_ILL) ? S_HALT : S_EXEC;
                S_EXEC:   r_state <= (w_class == C_CB || w_class == C_B)  ? S_FETCH :
                                     (w_class == C_LD || w_class == C_ST) ? S_MEM : S_WB;
                S_MEM:    if (bus.mem_ack) r_state <= (w_class == C_ST) ? S_FETCH : S_WB;
                S_WB:     r_state <= S_FETCH;
                default:  r_state <= S_HALT;
            endcase
        end
    end

    // ALU/SEU controls stay put from EXEC through MEM and WB so address and result remain stable
    always_comb begin
        w_ex           = r_state == S_EXEC;
        w_mem          = r_state == S_MEM;
        w_wb           = r_state == S_WB;
        w_alu          = w_ex || w_mem || w_wb;
        bus.ir_wr      = r_state == S_FETCH;
        bus.reg2loc    = (r_state == S_DECODE || w_ex || w_mem) && (w_class == C_ST || w_class == C_CB);
        bus.seu        = !w_alu             ? SEU_I  :
                         (w_class == C_CB)  ? SEU_CB :
                         (w_class == C_B)   ? SEU_B  :
                         (w_class == C_LD || w_class == C_ST) ? SEU_D : SEU_I;
        bus.alu_src    = w_alu && (w_class == C_I || w_class == C_LD || w_class == C_ST);
        bus.alu_op     = !w_alu            ? ALU_AND   :
                         (w_class == C_R)  ? w_r_alu   :
                         (w_class == C_CB) ? ALU_PASSB :
                         (w_class == C_B)  ? ALU_AND   : ALU_ADD;
        bus.mem_req    = w_mem;
        bus.mem_wr     = w_mem && w_class == C_ST;
        bus.reg_wr     = w_wb;
        bus.mem_to_reg = w_wb && w_class == C_LD;
        bus.pc_wr      = w_wb || (w_ex && (w_class == C_CB || w_class == C_B)) ||
                         (w_mem && w_class == C_ST && bus.mem_ack);
        bus.pc_src     = w_ex && (w_class == C_B || (w_class == C_CB && bus.zero));
        bus.halted     = r_state == S_HALT;
    end

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt, r_retired_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
        end else begin
            if (r_state != S_IDLE && r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (bus.pc_wr) r_retired_cnt <= r_retired_cnt + 1'b1;
        end
    end
    assign bus.cycle_cnt   = r_cycle_cnt;
    assign bus.retired_cnt = r_retired_cnt;
`else
    assign bus.cycle_cnt   = {CNT_W{1'b0}};
    assign bus.retired_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed per-cycle control vectors checked by a queue-driven monitor
module tb_multicycle_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    multicycle_sequencer_if #(.CNT_W(32)) bus ();
    multicycle_sequencer #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // vector layout: ir_wr pc_wr pc_src reg2loc | seu[1:0] | alu_src | alu_op[2:0] | mem_req mem_wr mem_to_reg reg_wr halted
    localparam logic [14:0] V0        = 15'b0;
    localparam logic [14:0] V_F       = {4'b1000, 2'b00, 1'b0, 3'b000, 5'b00000};
    localparam logic [14:0] V_D_REG   = {4'b0001, 2'b00, 1'b0, 3'b000, 5'b00000};
    localparam logic [14:0] ADD_EX    = {4'b0000, 2'b00, 1'b0, 3'b010, 5'b00000};
    localparam logic [14:0] ADD_WB    = {4'b0100, 2'b00, 1'b0, 3'b010, 5'b00010};
    localparam logic [14:0] SUB_EX    = {4'b0000, 2'b00, 1'b0, 3'b110, 5'b00000};
    localparam logic [14:0] SUB_WB    = {4'b0100, 2'b00, 1'b0, 3'b110, 5'b00010};
    localparam logic [14:0] ORR_EX    = {4'b0000, 2'b00, 1'b0, 3'b001, 5'b00000};
    localparam logic [14:0] ORR_WB    = {4'b0100, 2'b00, 1'b0, 3'b001, 5'b00010};
    localparam logic [14:0] ADDI_EX   = {4'b0000, 2'b00, 1'b1, 3'b010, 5'b00000};
    localparam logic [14:0] ADDI_WB   = {4'b0100, 2'b00, 1'b1, 3'b010, 5'b00010};
    localparam logic [14:0] B_EX      = {4'b0110, 2'b10, 1'b0, 3'b000, 5'b00000};
    localparam logic [14:0] ST_EX     = {4'b0001, 2'b01, 1'b1, 3'b010, 5'b00000};
    localparam logic [14:0] ST_MEM_A  = {4'b0101, 2'b01, 1'b1, 3'b010, 5'b11000};
    localparam logic [14:0] ST_MEM_W  = {4'b0001, 2'b01, 1'b1, 3'b010, 5'b11000};
    localparam logic [14:0] LD_EX     = {4'b0000, 2'b01, 1'b1, 3'b010, 5'b00000};
    localparam logic [14:0] LD_MEM    = {4'b0000, 2'b01, 1'b1, 3'b010, 5'b10000};
    localparam logic [14:0] LD_WB     = {4'b0100, 2'b01, 1'b1, 3'b010, 5'b00110};
    localparam logic [14:0] CB_EX_T   = {4'b0111, 2'b11, 1'b0, 3'b111, 5'b00000};
    localparam logic [14:0] CB_EX_F   = {4'b0101, 2'b11, 1'b0, 3'b111, 5'b00000};
    localparam logic [14:0] V_HALT    = 15'b000000000000001;

`ifdef SEQ_PERF_CNT_EN
    localparam logic [31:0] EXP_CY = 32'd11;
    localparam logic [31:0] EXP_RT = 32'd3;
`else
    localparam logic [31:0] EXP_CY = 32'd0;
    localparam logic [31:0] EXP_RT = 32'd0;
`endif

    typedef struct {
        logic [14:0] v;
        bit          c;
        logic [31:0] cy;
        logic [31:0] rt;
        string       n;
    } exp_t;
    exp_t sb[$];

    logic [14:0] act;
    assign act = {bus.ir_wr, bus.pc_wr, bus.pc_src, bus.reg2loc, bus.seu, bus.alu_src, bus.alu_op,
                  bus.mem_req, bus.mem_wr, bus.mem_to_reg, bus.reg_wr, bus.halted};

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            checks++;
            if (act !== x.v) begin
                errors++;
                $display("FAIL %s: got %b want %b", x.n, act, x.v);
            end
            if (x.c) begin
                checks += 2;
                if (bus.cycle_cnt !== x.cy) begin
                    errors++;
                    $display("FAIL %s cycle_cnt: got %0d want %0d", x.n, bus.cycle_cnt, x.cy);
                end
                if (bus.retired_cnt !== x.rt) begin
                    errors++;
                    $display("FAIL %s retired_cnt: got %0d want %0d", x.n, bus.retired_cnt, x.rt);
                end
            end
        end
    end

    task automatic push(input logic [14:0] e, input string n, input bit c, input logic [31:0] cy,
                        input logic [31:0] rt, input logic a, input logic z);
        exp_t x;
        x.v = e; x.c = c; x.cy = cy; x.rt = rt; x.n = n;
        bus.mem_ack = a;
        bus.zero    = z;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [14:0] e, input string n, input logic a = 1'b0, input logic z = 1'b0);
        push(e, n, 1'b0, 32'd0, 32'd0, a, z);
    endtask

    task automatic step_cnt(input logic [14:0] e, input string n, input logic [31:0] cy, input logic [31:0] rt);
        push(e, n, 1'b1, cy, rt, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.opcode  = 11'b0;
        bus.zero    = 1'b0;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        step_cnt(V0, "reset", 32'd0, 32'd0);
        step(V0, "reset_hold", 1'b1, 1'b1);
        rst_n = 1'b1;
        step(V0, "idle");
        bus.opcode = 11'b10001011000;
        step(V_F, "add_fetch");
        step(V0, "add_decode");
        step(ADD_EX, "add_exec");
        step(ADD_WB, "add_wb");
        bus.opcode = 11'b00010100011;
        step(V_F, "b_fetch");
        step(V0, "b_decode");
        step(B_EX, "b_exec");
        bus.opcode = 11'b11111000000;
        step(V_F, "st_fetch");
        step(V_D_REG, "st_decode");
        step(ST_EX, "st_exec");
        step(ST_MEM_A, "st_mem_ack", 1'b1);
        bus.opcode = 11'b11111000010;
        step_cnt(V_F, "ld_fetch_counters", EXP_CY, EXP_RT);
        step(V0, "ld_decode");
        step(LD_EX, "ld_exec");
        step(LD_MEM, "ld_mem_wait1", 1'b0);
        step(LD_MEM, "ld_mem_wait2", 1'b0);
        step(LD_MEM, "ld_mem_ack", 1'b1);
        step(LD_WB, "ld_wb");
        bus.opcode = 11'b10110100101;
        step(V_F, "cbz_t_fetch");
        step(V_D_REG, "cbz_t_decode");
        step(CB_EX_T, "cbz_taken_exec", 1'b1, 1'b1);
        step(V_F, "cbz_f_fetch");
        step(V_D_REG, "cbz_f_decode");
        step(CB_EX_F, "cbz_not_taken_exec", 1'b0, 1'b0);
        bus.opcode = 11'b10010001001;
        step(V_F, "addi_fetch");
        step(V0, "addi_decode");
        step(ADDI_EX, "addi_exec");
        step(ADDI_WB, "addi_wb");
        bus.opcode = 11'b11001011000;
        step(V_F, "sub_fetch");
        step(V0, "sub_decode");
        step(SUB_EX, "sub_exec");
        step(SUB_WB, "sub_wb");
        bus.opcode = 11'b10101010000;
        step(V_F, "orr_fetch");
        step(V0, "orr_decode");
        step(ORR_EX, "orr_exec");
        step(ORR_WB, "orr_wb");
        bus.opcode = 11'b11111000000;
        step(V_F, "st2_fetch");
        step(V_D_REG, "st2_decode");
        step(ST_EX, "st2_exec");
        step(ST_MEM_W, "st2_mem_wait", 1'b0);
        rst_n = 1'b0;
        step_cnt(V0, "reset_mid_mem", 32'd0, 32'd0);
        step(V0, "reset_mid_mem_hold");
        rst_n = 1'b1;
        bus.opcode = 11'b00000000000;
        step(V0, "idle_after_reset");
        step(V_F, "ill_fetch");
        step(V0, "ill_decode");
        for (int i = 0; i < 100; i++) step(V_HALT, "halt", i[0]);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
